// File: rtl/rob_multi_if.sv
// Bundle of the reorder-buffer interface: dispatch, write-back, operand lookup,
// commit and redirect. The ROB sits on the slave side.
interface rob_multi_if #(
  parameter int ID_W     = 4,
  parameter int WB_PORTS = 2
);
  logic                     rdy;
  logic                     flush_in;
  logic                     disp_valid;
  logic [4:0]               disp_dest;
  logic [1:0]               disp_kind;
  logic                     disp_ready;
  logic [31:0]              disp_value;
  logic [ID_W-1:0]          disp_tag;
  logic                     rob_full;
  logic                     rob_empty;
  logic [WB_PORTS-1:0]      wb_valid;
  logic [WB_PORTS*ID_W-1:0] wb_tag;
  logic [WB_PORTS*32-1:0]   wb_value;
  logic [WB_PORTS-1:0]      wb_redirect;
  logic [WB_PORTS*32-1:0]   wb_target;
  logic [ID_W-1:0]          q0_tag;
  logic [ID_W-1:0]          q1_tag;
  logic                     q0_ready;
  logic [31:0]              q0_value;
  logic                     q1_ready;
  logic [31:0]              q1_value;
  logic                     commit_valid;
  logic [ID_W-1:0]          commit_tag;
  logic [4:0]               commit_dest;
  logic [1:0]               commit_kind;
  logic [31:0]              commit_value;
  logic                     flush_out;
  logic [31:0]              flush_pc;

  modport master (
    output rdy, flush_in, disp_valid, disp_dest, disp_kind, disp_ready, disp_value,
           wb_valid, wb_tag, wb_value, wb_redirect, wb_target, q0_tag, q1_tag,
    input  disp_tag, rob_full, rob_empty, q0_ready, q0_value, q1_ready, q1_value,
           commit_valid, commit_tag, commit_dest, commit_kind, commit_value,
           flush_out, flush_pc
  );

  modport slave (
    input  rdy, flush_in, disp_valid, disp_dest, disp_kind, disp_ready, disp_value,
           wb_valid, wb_tag, wb_value, wb_redirect, wb_target, q0_tag, q1_tag,
    output disp_tag, rob_full, rob_empty, q0_ready, q0_value, q1_ready, q1_value,
           commit_valid, commit_tag, commit_dest, commit_kind, commit_value,
           flush_out, flush_pc
  );
endinterface

// File: rtl/rob_multi.sv
// Circular reorder buffer with multi-port write-back, in-order single commit,
// operand lookup with write-back bypass, and redirect/external flush.
module rob_multi #(
  parameter int DEPTH    = 16,
  parameter int WB_PORTS = 2,
  parameter int ID_W     = 4
) (
  input logic         clk,
  input logic         rst,
  rob_multi_if.slave  io
);

  logic [DEPTH-1:0]        busy, done, redir;
  logic [DEPTH-1:0][4:0]   dest;
  logic [DEPTH-1:0][1:0]   kind;
  logic [DEPTH-1:0][31:0]  value, target;
  logic [ID_W-1:0]         head, tail;
  logic [ID_W:0]           count;

  logic [DEPTH-1:0]        wb_hit, wb_red;
  logic [DEPTH-1:0][31:0]  wb_val, wb_tgt;

  logic                    full, empty, disp_acc, commit_fire;
  logic                    c_valid, f_out;
  logic [ID_W-1:0]         c_tag;
  logic [4:0]              c_dest;
  logic [1:0]              c_kind;
  logic [31:0]             c_value, f_pc;

  assign full        = (count == (ID_W+1)'(DEPTH));
  assign empty       = (count == '0);
  assign disp_acc    = io.disp_valid && !full && io.rdy;
  assign commit_fire = !empty && busy[head] && done[head];

  // Later ports overwrite earlier ones, so the highest-indexed port wins a tag.
  always_comb begin
    wb_hit = '0;
    wb_red = '0;
    wb_val = '0;
    wb_tgt = '0;
    for (int p = 0; p < WB_PORTS; p++) begin
      if (io.wb_valid[p] && busy[io.wb_tag[p*ID_W +: ID_W]]) begin
        wb_hit[io.wb_tag[p*ID_W +: ID_W]] = 1'b1;
        wb_red[io.wb_tag[p*ID_W +: ID_W]] = io.wb_redirect[p];
        wb_val[io.wb_tag[p*ID_W +: ID_W]] = io.wb_value[p*32 +: 32];
        wb_tgt[io.wb_tag[p*ID_W +: ID_W]] = io.wb_target[p*32 +: 32];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy    <= '0;
      done    <= '0;
      redir   <= '0;
      dest    <= '0;
      kind    <= '0;
      value   <= '0;
      target  <= '0;
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      c_valid <= 1'b0;
      c_tag   <= '0;
      c_dest  <= '0;
      c_kind  <= '0;
      c_value <= '0;
      f_out   <= 1'b0;
      f_pc    <= '0;
    end else if (!io.rdy) begin
      c_valid <= 1'b0;
      f_out   <= 1'b0;
    end else begin
      c_valid <= 1'b0;
      f_out   <= 1'b0;
      if (io.flush_in) begin
        busy  <= '0;
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        for (int e = 0; e < DEPTH; e++) begin
          if (wb_hit[e]) begin
            done[e]   <= 1'b1;
            value[e]  <= wb_val[e];
            redir[e]  <= wb_red[e];
            target[e] <= wb_tgt[e];
          end
        end
        // Tail entry is never busy when dispatch is accepted, so no write-back collides.
        if (disp_acc) begin
          busy[tail]   <= 1'b1;
          done[tail]   <= io.disp_ready;
          redir[tail]  <= 1'b0;
          dest[tail]   <= io.disp_dest;
          kind[tail]   <= io.disp_kind;
          value[tail]  <= io.disp_value;
          target[tail] <= '0;
          tail         <= tail + ID_W'(1);
        end
        if (commit_fire) begin
          c_valid    <= 1'b1;
          c_tag      <= head;
          c_dest     <= dest[head];
          c_kind     <= kind[head];
          c_value    <= value[head];
          busy[head] <= 1'b0;
          head       <= head + ID_W'(1);
        end
        case ({disp_acc, commit_fire})
          2'b10:   count <= count + (ID_W+1)'(1);
          2'b01:   count <= count - (ID_W+1)'(1);
          default: count <= count;
        endcase
        // A redirecting commit squashes everything younger, including this cycle's dispatch.
        if (commit_fire && redir[head]) begin
          f_out <= 1'b1;
          f_pc  <= target[head];
          busy  <= '0;
          head  <= '0;
          tail  <= '0;
          count <= '0;
        end
      end
    end
  end

  assign io.disp_tag     = tail;
  assign io.rob_full     = full;
  assign io.rob_empty    = empty;
  assign io.q0_ready     = busy[io.q0_tag] && (done[io.q0_tag] || wb_hit[io.q0_tag]);
  assign io.q0_value     = wb_hit[io.q0_tag] ? wb_val[io.q0_tag] : value[io.q0_tag];
  assign io.q1_ready     = busy[io.q1_tag] && (done[io.q1_tag] || wb_hit[io.q1_tag]);
  assign io.q1_value     = wb_hit[io.q1_tag] ? wb_val[io.q1_tag] : value[io.q1_tag];
  assign io.commit_valid = c_valid;
  assign io.commit_tag   = c_tag;
  assign io.commit_dest  = c_dest;
  assign io.commit_kind  = c_kind;
  assign io.commit_value = c_value;
  assign io.flush_out    = f_out;
  assign io.flush_pc     = f_pc;

endmodule

// File: tb/tb_rob_multi.sv
// Directed bench for rob_multi: fill/full, out-of-order write-back, port priority,
// redirect, wrap-around streaming, rdy stall, flush and mid-run reset.
module tb_rob_multi;
  localparam int DEPTH = 16, WB_PORTS = 2, ID_W = 4;

  logic clk, rst;
  int   n_vec = 0, n_err = 0;

  rob_multi_if #(.ID_W(ID_W), .WB_PORTS(WB_PORTS)) bus ();
  rob_multi #(.DEPTH(DEPTH), .WB_PORTS(WB_PORTS), .ID_W(ID_W)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.disp_valid  = 1'b0;
    bus.disp_dest   = '0;
    bus.disp_kind   = '0;
    bus.disp_ready  = 1'b0;
    bus.disp_value  = '0;
    bus.wb_valid    = '0;
    bus.wb_tag      = '0;
    bus.wb_value    = '0;
    bus.wb_redirect = '0;
    bus.wb_target   = '0;
    bus.flush_in    = 1'b0;
  endtask

  task automatic disp(input logic [4:0] d, input logic [1:0] k, input logic r, input logic [31:0] v);
    bus.disp_valid = 1'b1;
    bus.disp_dest  = d;
    bus.disp_kind  = k;
    bus.disp_ready = r;
    bus.disp_value = v;
  endtask

  task automatic wb(input int p, input logic [3:0] t, input logic [31:0] v,
                    input logic r, input logic [31:0] tg);
    bus.wb_valid[p]           = 1'b1;
    bus.wb_tag[p*ID_W +: ID_W] = t;
    bus.wb_value[p*32 +: 32]  = v;
    bus.wb_redirect[p]        = r;
    bus.wb_target[p*32 +: 32] = tg;
  endtask

  initial begin
    rst = 1'b1;
    bus.rdy = 1'b1;
    bus.q0_tag = '0;
    bus.q1_tag = '0;
    idle();
    #1 rst = 1'b0;
    tick(); tick();
    chk("rst_empty", bus.rob_empty, 1);
    chk("rst_full", bus.rob_full, 0);
    chk("rst_tag", bus.disp_tag, 0);
    chk("rst_cv", bus.commit_valid, 0);
    chk("rst_fo", bus.flush_out, 0);
    chk("rst_cval", bus.commit_value, 0);
    chk("rst_fpc", bus.flush_pc, 0);
    rst = 1'b1;
    tick();

    // fill to full, 17th dispatch refused
    for (int i = 0; i < 16; i++) begin
      disp(5'(i), 2'd0, 1'b0, 32'(i));
      chk("fill_tag", bus.disp_tag, 32'(i));
      tick();
    end
    chk("full_set", bus.rob_full, 1);
    tick();
    chk("full_refuse_tag", bus.disp_tag, 0);
    chk("full_hold", bus.rob_full, 1);
    chk("full_no_cv", bus.commit_valid, 0);
    idle();
    bus.flush_in = 1'b1;
    tick();
    idle();
    chk("flush_empty", bus.rob_empty, 1);
    chk("flush_tag", bus.disp_tag, 0);
    chk("flush_no_fo", bus.flush_out, 0);

    // out-of-order write-back, in-order commit
    for (int i = 0; i < 3; i++) begin
      disp(5'(i + 1), 2'd0, 1'b0, 32'h0);
      tick();
    end
    idle();
    wb(0, 4'd0, 32'hC, 1'b0, 32'h0);
    tick();
    chk("wb_latency_cv", bus.commit_valid, 0);
    idle();
    wb(0, 4'd2, 32'hA, 1'b0, 32'h0);
    wb(1, 4'd1, 32'hB, 1'b0, 32'h0);
    tick();
    idle();
    chk("ooo_c0_tag", bus.commit_tag, 0);
    chk("ooo_c0_val", bus.commit_value, 32'hC);
    chk("ooo_c0_dest", bus.commit_dest, 1);
    tick();
    chk("ooo_c1_tag", bus.commit_tag, 1);
    chk("ooo_c1_val", bus.commit_value, 32'hB);
    tick();
    chk("ooo_c2_tag", bus.commit_tag, 2);
    chk("ooo_c2_val", bus.commit_value, 32'hA);
    chk("ooo_c2_cv", bus.commit_valid, 1);
    tick();
    chk("ooo_idle_cv", bus.commit_valid, 0);
    chk("ooo_empty", bus.rob_empty, 1);

    // both ports hit tag 3: port 1 wins, bypass visible same cycle
    chk("p_tag3", bus.disp_tag, 3);
    disp(5'd7, 2'd0, 1'b0, 32'h0);
    tick();
    idle();
    bus.q0_tag = 4'd3;
    bus.q1_tag = 4'd3;
    #1;
    chk("p_q1_notready", bus.q1_ready, 0);
    wb(0, 4'd3, 32'h11, 1'b0, 32'h0);
    wb(1, 4'd3, 32'h22, 1'b0, 32'h0);
    #1;
    chk("p_byp_rdy", bus.q0_ready, 1);
    chk("p_byp_val", bus.q0_value, 32'h22);
    tick();
    idle();
    #1;
    chk("p_store_val", bus.q0_value, 32'h22);
    tick();
    chk("p_commit_tag", bus.commit_tag, 3);
    chk("p_commit_val", bus.commit_value, 32'h22);

    // redirect at tag 5; same-cycle dispatch discarded
    disp(5'd4, 2'd0, 1'b1, 32'h44);
    tick();
    disp(5'd5, 2'd2, 1'b0, 32'h0);
    tick();
    chk("br_c4_cv", bus.commit_valid, 1);
    chk("br_c4_tag", bus.commit_tag, 4);
    chk("br_c4_val", bus.commit_value, 32'h44);
    disp(5'd6, 2'd0, 1'b0, 32'h0);
    tick();
    idle();
    wb(1, 4'd5, 32'h55, 1'b1, 32'h100);
    tick();
    idle();
    disp(5'd8, 2'd0, 1'b1, 32'h88);
    tick();
    idle();
    chk("br_cv", bus.commit_valid, 1);
    chk("br_tag", bus.commit_tag, 5);
    chk("br_kind", bus.commit_kind, 2);
    chk("br_fo", bus.flush_out, 1);
    chk("br_fpc", bus.flush_pc, 32'h100);
    chk("br_empty", bus.rob_empty, 1);
    chk("br_tag0", bus.disp_tag, 0);
    tick();
    chk("br_fo_pulse", bus.flush_out, 0);
    chk("br_cv_off", bus.commit_valid, 0);

    // fill to 14, then stream 20 commits while dispatching
    for (int i = 0; i < 14; i++) begin
      disp(5'(i), 2'd0, 1'b0, 32'(i));
      if (i == 13) wb(0, 4'd0, 32'h200, 1'b0, 32'h0);
      tick();
      idle();
    end
    for (int c = 0; c < 20; c++) begin
      disp(5'd9, 2'd0, 1'b1, 32'h300 + 32'(c));
      if (c + 1 <= 13) wb(0, 4'(c + 1), 32'h200 + 32'(c + 1), 1'b0, 32'h0);
      tick();
      idle();
      chk("wrap_cv", bus.commit_valid, 1);
      chk("wrap_ctag", bus.commit_tag, 32'(c % 16));
      chk("wrap_cval", bus.commit_value, (c < 14) ? 32'h200 + 32'(c) : 32'h300 + 32'(c - 14));
      chk("wrap_dtag", bus.disp_tag, 32'((15 + c) % 16));
      chk("wrap_full", bus.rob_full, 0);
    end
    // flush beats a ready head commit
    bus.flush_in = 1'b1;
    tick();
    idle();
    chk("fin_no_cv", bus.commit_valid, 0);
    chk("fin_no_fo", bus.flush_out, 0);
    chk("fin_empty", bus.rob_empty, 1);

    // rdy low stalls a ready head; dispatch also refused
    disp(5'd1, 2'd0, 1'b1, 32'h77);
    tick();
    bus.rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_cv", bus.commit_valid, 0);
      chk("stall_tag", bus.disp_tag, 1);
    end
    idle();
    bus.rdy = 1'b1;
    tick();
    chk("stall_rel_cv", bus.commit_valid, 1);
    chk("stall_rel_val", bus.commit_value, 32'h77);

    // write-back to an idle entry is ignored
    wb(0, 4'd1, 32'h99, 1'b1, 32'h500);
    tick();
    idle();
    disp(5'd2, 2'd0, 1'b0, 32'h5);
    tick();
    idle();
    bus.q0_tag = 4'd1;
    #1;
    chk("nb_q_rdy", bus.q0_ready, 0);
    chk("nb_q_val", bus.q0_value, 32'h5);
    chk("nb_fo", bus.flush_out, 0);

    // asynchronous reset mid-run
    disp(5'd3, 2'd0, 1'b1, 32'h6);
    tick();
    idle();
    #2 rst = 1'b0;
    #1;
    chk("arst_empty", bus.rob_empty, 1);
    chk("arst_tag", bus.disp_tag, 0);
    tick();
    rst = 1'b1;
    disp(5'd4, 2'd0, 1'b1, 32'hAB);
    tick();
    idle();
    chk("arst_next_tag", bus.disp_tag, 1);
    tick();
    chk("arst_c_tag", bus.commit_tag, 0);
    chk("arst_c_val", bus.commit_value, 32'hAB);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/rob_multi.md
ROB_MULTI -- requirements
Module: rob_multi

Interface
REQ-001 Parameter DEPTH, default 16: entry count, power of two, >=4.
REQ-002 Parameter WB_PORTS, default 2: number of write-back ports.
REQ-003 Parameter ID_W, default 4: tag width, equals log2(DEPTH).
REQ-004 clk  in  1  single clock, rising edge.
REQ-005 rst  in  1  asynchronous active-low reset.
REQ-006 rdy  in  1  global enable; low freezes state.
REQ-007 disp_valid  in  1  dispatch request.
REQ-008 disp_dest, disp_kind, disp_ready, disp_value  in  5, 2, 1, 32  entry fields; kind 0=normal, 1=store, 2=branch, 3=jalr; disp_ready marks a result that is already computed.
REQ-009 disp_tag  out  ID_W  combinational, equals tail.
REQ-010 rob_full, rob_empty  out  1 each  combinational from count.
REQ-011 wb_valid  in  WB_PORTS  one completion bit per port.
REQ-012 wb_tag, wb_value, wb_redirect, wb_target  in  WB_PORTS*ID_W, *32, *1, *32  packed, port p at slice p.
REQ-013 q0_tag, q1_tag  in  ID_W  operand lookup tags.
REQ-014 q0_ready, q0_value, q1_ready, q1_value  out  1, 32, 1, 32  combinational lookup result.
REQ-015 flush_in  in  1  external flush.
REQ-016 commit_valid, commit_tag, commit_dest, commit_kind, commit_value  out  1, ID_W, 5, 2, 32  registered commit.
REQ-017 flush_out, flush_pc  out  1, 32  registered redirect.

Function
REQ-018 Per-entry state: busy, done, redirect, dest, kind, value, target. Pointers head and tail are ID_W bits and wrap modulo DEPTH. count is ID_W+1 bits.
REQ-019 rob_full = (count==DEPTH); rob_empty = (count==0).
REQ-020 A dispatch is accepted when disp_valid && !rob_full && rdy. It writes the entry at tail with busy=1, done=disp_ready, redirect=0 and value=disp_value, then advances tail by 1.
REQ-021 For each p with wb_valid[p] whose tagged entry is busy: set done=1, value=wb_value, redirect=wb_redirect, target=wb_target. Write-backs to non-busy entries are ignored.
REQ-022 If several ports target the same tag in one cycle, the highest-indexed port wins.
REQ-023 Commit occurs when !rob_empty && busy[head] && done[head]. The next edge loads commit_valid=1 and the head fields, clears busy[head] and advances head.
REQ-024 Write-back latency: an entry written back at edge M commits at edge M+1 at the earliest. A disp_ready entry dispatched at edge N commits at edge N+1 at the earliest.
REQ-025 Only one commit per cycle; commit_valid is low in any cycle without a commit.
REQ-026 count update: +1 on dispatch only, -1 on commit only, unchanged when both occur or neither occurs.
REQ-027 When full, dispatch is refused even if a commit occurs in the same cycle, because full is the registered view.
REQ-028 A committed entry with redirect=1 also loads flush_out=1 and flush_pc=target for one cycle. In the same edge it clears all busy bits and sets head=tail=count=0. Any same-cycle dispatch is discarded.
REQ-029 flush_in=1 clears all busy bits and sets head=tail=count=0 with no commit. It takes priority over dispatch, write-back and commit in that cycle. flush_out stays 0.
REQ-030 Lookup: qX_ready=1 when the entry is busy and either done or receiving a write-back this cycle. The bypass value comes from the winning port per REQ-022; otherwise it is the stored value.
REQ-031 With rdy=0 all entries, pointers and count hold. commit_valid and flush_out are driven to 0 at that edge.
REQ-032 Wrap-around: when tail or head steps from DEPTH-1 it goes to 0. Behaviour is identical across the wrap.

Reset
REQ-033 When rst is low, asynchronously: head=tail=count=0, all busy/done/redirect=0, commit_valid=0, flush_out=0. commit_tag, commit_dest, commit_kind, commit_value and flush_pc are all 0.
REQ-034 Reset mid-operation discards all entries. The first dispatch after release receives tag 0.

Verification
REQ-035 Dispatch 16 entries with disp_ready=0 -> rob_full=1 on cycle 16. A 17th dispatch is refused and tail stays 0.
REQ-036 Tags 2 and 1 are written back on the same edge with values 0xA and 0xB -> commit order is tag0, then 1, then 2, with 0xB before 0xA.
REQ-037 Port 0 and port 1 both write tag 3 with values 0x11 and 0x22 -> the stored value is 0x22. q0_tag=3 shows ready=1, value=0x22 in that same cycle.
REQ-038 A branch at tag 5 is written back with redirect=1 and target 0x100 -> at commit, flush_out=1 and flush_pc=0x100. count=0 the next cycle and the next disp_tag=0.
REQ-039 Fill to 14, commit 20 entries while dispatching continuously -> pointers wrap, count stays constant and commit tags are sequential modulo 16.
REQ-040 rdy is held low for 3 cycles while the head is done -> no commit_valid during those cycles. The commit occurs on the first edge with rdy=1.
